sync_debounce_bank: RTL and testbench

- Multi-channel input conditioner: WIDTH independent asynchronous inputs.
- Each channel passes through an NUM_STAGES flip-flop synchronizer, then a per-channel debounce filter.
- Each channel produces a stable level plus single-cycle rise and fall strobes.
- Sits at the chip boundary between buttons, switches or external status pins and the synchronous core logic.

---
 rtl/sync_debounce_bank.sv | 63 ++++++
 tb/tb_sync_debounce_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_bank.sv
// rtl/sync_debounce_bank.sv - multi-channel input synchronizer and debounce filter with edge strobes
module sync_debounce_bank #(
   parameter int               WIDTH           = 4,
   parameter int               NUM_STAGES      = 2,
   parameter int               DEBOUNCE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Input,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Rise,
   output logic [WIDTH-1:0] Fall,
   output logic             AnyChange
);
   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] stage_q [NUM_STAGES];
   logic [CW-1:0]    cnt_q   [WIDTH];
   logic [CW-1:0]    cnt_d   [WIDTH];
   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] next_out;

   assign sync_s = stage_q[NUM_STAGES-1];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= RESET_VALUE;
      end else begin
         stage_q[0] <= Input;
         for (int k = 1; k < NUM_STAGES; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   // A channel flips only on the edge where its run of disagreeing samples reaches the limit.
   always_comb begin
      next_out = Output;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_s[i] != Output[i]) begin
            if (cnt_q[i] == CNT_LAST) next_out[i] = sync_s[i];
            else                      cnt_d[i]    = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Output    <= RESET_VALUE;
         Rise      <= '0;
         Fall      <= '0;
         AnyChange <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         Output    <= next_out;
         Rise      <= ~Output & next_out;
         Fall      <= Output & ~next_out;
         AnyChange <= |(Output ^ next_out);
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb/tb_sync_debounce_bank.sv - self-checking bench for sync_debounce_bank, default and swept parameters
module tb_sync_debounce_bank;
   localparam int         NA  = 2;
   localparam int         DA  = 4;
   localparam logic [3:0] RVA = 4'h0;
   localparam int         NB  = 3;
   localparam int         DB  = 1;
   localparam logic       RVB = 1'b1;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic [3:0] in_a = 4'h0;
   logic [3:0] out_a, rise_a, fall_a;
   logic       any_a;
   logic [0:0] in_b = 1'b1;
   logic [0:0] out_b, rise_b, fall_b;
   logic       any_b;

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   sync_debounce_bank dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .Input(in_a),
      .Output(out_a), .Rise(rise_a), .Fall(fall_a), .AnyChange(any_a)
   );

   sync_debounce_bank #(.WIDTH(1), .NUM_STAGES(NB), .DEBOUNCE_CYCLES(DB), .RESET_VALUE(RVB)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .Input(in_b),
      .Output(out_b), .Rise(rise_b), .Fall(fall_b), .AnyChange(any_b)
   );

   // Reference: the sample seen at edge k was the input captured N edges earlier; a channel
   // flips at edge n when every such sample in the last D edges (all after its previous flip)
   // disagrees with the current level.
   int         a_edge;
   logic [3:0] a_hist[$];
   logic [3:0] a_out, a_rise, a_fall;
   logic       a_any;
   int         a_last[4];
   int         b_edge;
   logic [0:0] b_hist[$];
   logic [0:0] b_out, b_rise, b_fall;
   logic       b_any;
   int         b_last;

   always @(posedge Clk or negedge Reset_n) begin : model_a
      logic [3:0] h;
      logic       flip;
      if (!Reset_n) begin
         a_edge = 0; a_hist.delete(); a_out = RVA; a_rise = '0; a_fall = '0; a_any = 1'b0;
         for (int c = 0; c < 4; c++) a_last[c] = 0;
      end else begin
         a_edge++;
         a_hist.push_back(in_a);
         a_rise = '0; a_fall = '0;
         for (int c = 0; c < 4; c++) begin
            flip = 1'b1;
            for (int k = a_edge - DA + 1; k <= a_edge; k++) begin
               h = (k - NA >= 1) ? a_hist[k-NA-1] : RVA;
               if (k <= a_last[c] || h[c] == a_out[c]) flip = 1'b0;
            end
            if (flip) begin
               a_out[c] = ~a_out[c]; a_rise[c] = a_out[c]; a_fall[c] = ~a_out[c]; a_last[c] = a_edge;
            end
         end
         a_any = |(a_rise | a_fall);
      end
   end

   always @(posedge Clk or negedge Reset_n) begin : model_b
      logic [0:0] h;
      logic       flip;
      if (!Reset_n) begin
         b_edge = 0; b_hist.delete(); b_out = RVB; b_rise = '0; b_fall = '0; b_any = 1'b0; b_last = 0;
      end else begin
         b_edge++;
         b_hist.push_back(in_b);
         b_rise = '0; b_fall = '0;
         flip = 1'b1;
         for (int k = b_edge - DB + 1; k <= b_edge; k++) begin
            h = (k - NB >= 1) ? b_hist[k-NB-1] : RVB;
            if (k <= b_last || h == b_out) flip = 1'b0;
         end
         if (flip) begin
            b_out = ~b_out; b_rise = b_out; b_fall = ~b_out; b_last = b_edge;
         end
         b_any = |(b_rise | b_fall);
      end
   end

   task automatic test_reset();
      Reset_n = 1'b0; in_a = 4'hF; in_b = 1'b0;
      repeat (3) @(negedge Clk);
      tests++; if (out_a !== 4'h0) begin fails++; $display("FAIL reset_out_a: got %b expected 0000", out_a); end
      tests++; if ({rise_a, fall_a, any_a} !== 9'b0) begin fails++; $display("FAIL reset_strobes_a: got %b expected 0", {rise_a, fall_a, any_a}); end
      tests++; if (out_b !== 1'b1) begin fails++; $display("FAIL reset_out_b: got %b expected 1", out_b); end
      tests++; if ({rise_b, fall_b, any_b} !== 3'b0) begin fails++; $display("FAIL reset_strobes_b: got %b expected 0", {rise_b, fall_b, any_b}); end
   endtask

   task automatic test_clean_rise();
      in_a = 4'b0001; in_b = 1'b1; Reset_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge Clk);
         tests++;
         if (out_a[0] !== (e >= 6) || rise_a[0] !== (e == 6) || fall_a !== 4'b0) begin
            fails++; $display("FAIL clean_rise edge %0d: out=%b rise=%b fall=%b", e, out_a, rise_a, fall_a);
         end
         tests++;
         if ({out_a, rise_a, fall_a, any_a} !== {a_out, a_rise, a_fall, a_any}) begin
            fails++; $display("FAIL clean_rise_model edge %0d: got %b expected %b", e, {out_a, rise_a, fall_a, any_a}, {a_out, a_rise, a_fall, a_any});
         end
      end
   endtask

   task automatic test_glitch();
      in_a = 4'b0011;
      repeat (3) @(negedge Clk);
      in_a = 4'b0001;
      for (int e = 1; e <= 10; e++) begin
         @(negedge Clk);
         tests++;
         if (out_a[1] !== 1'b0 || rise_a[1] !== 1'b0 || fall_a[1] !== 1'b0) begin
            fails++; $display("FAIL glitch_reject cycle %0d: out=%b rise=%b fall=%b expected ch1 quiet", e, out_a, rise_a, fall_a);
         end
      end
      in_a = 4'b0011;
      for (int e = 1; e <= 8; e++) begin
         @(negedge Clk);
         tests++;
         if (out_a[1] !== (e >= 6) || rise_a[1] !== (e == 6)) begin
            fails++; $display("FAIL glitch_accept edge %0d: out=%b rise=%b", e, out_a, rise_a);
         end
         tests++;
         if ({out_a, rise_a, fall_a, any_a} !== {a_out, a_rise, a_fall, a_any}) begin
            fails++; $display("FAIL glitch_model edge %0d: got %b expected %b", e, {out_a, rise_a, fall_a, any_a}, {a_out, a_rise, a_fall, a_any});
         end
      end
   endtask

   task automatic test_clean_fall();
      in_a = 4'b0111;
      repeat (8) @(negedge Clk);
      tests++; if (out_a !== 4'b0111) begin fails++; $display("FAIL fall_setup: got %b expected 0111", out_a); end
      in_a = 4'b0011;
      for (int e = 1; e <= 8; e++) begin
         @(negedge Clk);
         tests++;
         if (out_a[2] !== (e < 6) || fall_a[2] !== (e == 6) || rise_a !== 4'b0 || any_a !== (e == 6)) begin
            fails++; $display("FAIL clean_fall edge %0d: out=%b fall=%b rise=%b any=%b", e, out_a, fall_a, rise_a, any_a);
         end
      end
   endtask

   task automatic test_simultaneous();
      Reset_n = 1'b0;
      #1 in_a = 4'b1010;
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge Clk);
         tests++;
         if (out_a !== ((e >= 6) ? 4'b1010 : 4'b0000) || rise_a !== ((e == 6) ? 4'b1010 : 4'b0000) ||
             fall_a !== 4'b0 || any_a !== (e == 6)) begin
            fails++; $display("FAIL simultaneous edge %0d: out=%b rise=%b fall=%b any=%b", e, out_a, rise_a, fall_a, any_a);
         end
      end
   endtask

   task automatic test_async_reset_mid();
      in_a = 4'b0101;
      repeat (3) @(negedge Clk);
      tests++; if (out_a !== 4'b1010) begin fails++; $display("FAIL midcount_hold: got %b expected 1010", out_a); end
      #2 Reset_n = 1'b0;
      #1;
      tests++; if (out_a !== 4'b0000 || {rise_a, fall_a, any_a} !== 9'b0) begin
         fails++; $display("FAIL async_reset_a: out=%b strobes=%b expected 0", out_a, {rise_a, fall_a, any_a});
      end
      tests++; if (out_b !== 1'b1) begin fails++; $display("FAIL async_reset_b: got %b expected 1", out_b); end
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge Clk);
         tests++;
         if (out_a !== ((e >= 6) ? 4'b0101 : 4'b0000) || rise_a !== ((e == 6) ? 4'b0101 : 4'b0000)) begin
            fails++; $display("FAIL after_reset edge %0d: out=%b rise=%b", e, out_a, rise_a);
         end
      end
   endtask

   task automatic test_sweep();
      Reset_n = 1'b0;
      #1 begin in_a = 4'b0000; in_b = 1'b0; end
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(negedge Clk);
         tests++;
         if (out_b !== (e < 4) || fall_b !== (e == 4) || rise_b !== 1'b0 || any_b !== (e == 4)) begin
            fails++; $display("FAIL sweep_fall edge %0d: out=%b fall=%b rise=%b any=%b", e, out_b, fall_b, rise_b, any_b);
         end
      end
      for (int e = 1; e <= 20; e++) begin
         in_b = ~in_b;
         in_a = in_a ^ 4'b1000;
         @(negedge Clk);
         tests++;
         if (out_a !== 4'b0000 || any_a !== 1'b0) begin
            fails++; $display("FAIL toggle_hold cycle %0d: out=%b any=%b expected 0000/0", e, out_a, any_a);
         end
         tests++;
         if ({out_b, rise_b, fall_b, any_b} !== {b_out, b_rise, b_fall, b_any}) begin
            fails++; $display("FAIL sweep_toggle_model cycle %0d: got %b expected %b", e, {out_b, rise_b, fall_b, any_b}, {b_out, b_rise, b_fall, b_any});
         end
      end
   endtask

   task automatic test_random();
      int hold[4];
      for (int c = 0; c < 4; c++) hold[c] = 1;
      for (int e = 0; e < 400; e++) begin
         for (int c = 0; c < 4; c++) begin
            hold[c]--;
            if (hold[c] == 0) begin
               in_a[c] = ~in_a[c];
               hold[c] = $urandom_range(1, 7);
            end
         end
         in_b = 1'($urandom);
         @(negedge Clk);
         tests++;
         if ({out_a, rise_a, fall_a, any_a} !== {a_out, a_rise, a_fall, a_any}) begin
            fails++; $display("FAIL random_a cycle %0d: got %b expected %b", e, {out_a, rise_a, fall_a, any_a}, {a_out, a_rise, a_fall, a_any});
         end
         tests++;
         if ({out_b, rise_b, fall_b, any_b} !== {b_out, b_rise, b_fall, b_any}) begin
            fails++; $display("FAIL random_b cycle %0d: got %b expected %b", e, {out_b, rise_b, fall_b, any_b}, {b_out, b_rise, b_fall, b_any});
         end
         tests++;
         if ((rise_a & fall_a) !== 4'b0) begin
            fails++; $display("FAIL rise_fall_exclusive cycle %0d: rise=%b fall=%b", e, rise_a, fall_a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_glitch();
      test_clean_fall();
      test_simultaneous();
      test_async_reset_mid();
      test_sweep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
